image_window_renderer: RTL and testbench



---
 rtl/image_window_renderer_pkg.sv | 25 ++
 rtl/image_window_renderer_if.sv | 29 ++
 rtl/image_window_renderer_valid_delay_line.sv | 26 ++
 rtl/image_window_renderer.sv | 166 ++++++++++++++++
 tb/tb_image_window_renderer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/image_window_renderer_pkg.sv
// Shared types and constants for image_window_renderer.
package renderer_pkg;

  typedef enum logic [1:0] {
    FRAME_WAIT  = 2'd0,
    LINE_WAIT   = 2'd1,
    LINE_ACTIVE = 2'd2
  } state_t;

  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned V_TOTAL = 525;

  localparam logic [23:0] BORDER_COLOR = 24'hFF0000;

  // Number of pixels in one stored image.
  function automatic int unsigned img_size(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Select width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_window_renderer_if.sv
// Scan-position, image-memory and colour bus between timing, renderer and RAM.
interface image_window_renderer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SEL_W  = 1
);
  logic [9:0]        hs;
  logic [9:0]        vs;
  logic [SEL_W-1:0]  img_sel;
  logic [PIX_W-1:0]  pixel_data;
  logic [ADDR_W-1:0] pixel_address;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              frame_start;
  logic [SEL_W-1:0]  active_img;

  // Renderer side.
  modport master (
    input  hs, vs, img_sel, pixel_data,
    output pixel_address, r, g, b, frame_start, active_img
  );

  // Timing generator / memory / display side.
  modport slave (
    output hs, vs, img_sel, pixel_data,
    input  pixel_address, r, g, b, frame_start, active_img
  );
endinterface

// File: rtl/image_window_renderer_valid_delay_line.sv
// Fixed-depth flag shift register aligning window flags with memory read data.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift flags one stage per clock; cleared on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/image_window_renderer.sv
// Grayscale image window renderer: maps the VGA scan onto one of NUM_IMAGES
// stacked frame buffers, with integer up-scaling and memory-latency alignment.
// Optional macro RENDERER_BORDER_EN draws a 1-pixel red frame around the window.
module image_window_renderer
  import renderer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 400,
  parameter int unsigned IMG_HEIGHT  = 400,
  parameter int unsigned NUM_IMAGES  = 2,
  parameter int unsigned H_START     = 120,
  parameter int unsigned V_START     = 40,
  parameter int unsigned SCALE       = 1,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic              clk_25,
  input  logic              rst,
  image_window_renderer_if.master bus
);

  localparam int unsigned SEL_W    = sel_width(NUM_IMAGES);
  localparam int unsigned IMG_SIZE = img_size(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned H_END    = H_START + IMG_WIDTH * SCALE;
  localparam int unsigned V_END    = V_START + IMG_HEIGHT * SCALE;
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH + 1);
  localparam int unsigned SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned DLY      = MEM_LATENCY + 1;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_row_base, w_row_base_next;
  logic [COL_W-1:0]    r_col, w_col_next, w_col_cur;
  logic [SUB_W-1:0]    r_xsub, w_xsub_next, w_xsub_cur;
  logic [SUB_W-1:0]    r_ysub, w_ysub_next;
  logic [SEL_W-1:0]    r_active_img, w_active_next;
  logic                r_frame_start;
  logic [ADDR_W-1:0]   r_pixel_address;
  logic [23:0]         r_rgb;

  logic [31:0]         w_hs_x, w_vs_x;
  logic                w_in_win, w_pix_en, w_border, w_frame_latch, w_last_line_done;
  logic [ADDR_W-1:0]   w_base_next, w_addr;
  logic [1:0]          w_dly_q;
  logic [7:0]          w_gray;

  assign w_hs_x = 32'(bus.hs);
  assign w_vs_x = 32'(bus.vs);

  // Window membership with bounds evaluated at 32 bits so they never overflow.
  assign w_in_win = (w_hs_x >= H_START) && (w_hs_x < H_END) &&
                    (w_vs_x >= V_START) && (w_vs_x < V_END);

  assign w_frame_latch    = (bus.hs == 10'd0) && (bus.vs == 10'd0);
  assign w_last_line_done = (w_vs_x == V_END - 1) && (w_hs_x >= H_END);
  assign w_active_next    = (32'(bus.img_sel) < NUM_IMAGES) ? bus.img_sel : r_active_img;
  assign w_base_next      = ADDR_W'(32'(w_active_next) * IMG_SIZE);

  // Until the first frame latch the bases are unknown, so window pixels stay dark.
  assign w_pix_en = w_in_win && (r_state != FRAME_WAIT);

  // Counters describe the pixel currently presented; a fresh line starts at column 0.
  assign w_col_cur  = (r_state == LINE_ACTIVE) ? r_col  : '0;
  assign w_xsub_cur = (r_state == LINE_ACTIVE) ? r_xsub : '0;
  assign w_addr     = r_row_base + ADDR_W'(w_col_cur);

`ifdef RENDERER_BORDER_EN
  // One-pixel frame just outside the window, corners included.
  assign w_border =
    (((w_hs_x + 32'd1 == H_START) || (w_hs_x == H_END)) &&
     (w_vs_x + 32'd1 >= V_START) && (w_vs_x <= V_END)) ||
    (((w_vs_x + 32'd1 == V_START) || (w_vs_x == V_END)) &&
     (w_hs_x + 32'd1 >= H_START) && (w_hs_x <= H_END));
`else
  assign w_border = 1'b0;
`endif

  // Next-state and counter update for the scan walker.
  always_comb begin
    w_state_next    = r_state;
    w_row_base_next = r_row_base;
    w_col_next      = r_col;
    w_xsub_next     = r_xsub;
    w_ysub_next     = r_ysub;
    if (w_frame_latch) begin
      w_state_next    = LINE_WAIT;
      w_row_base_next = w_base_next;
      w_col_next      = '0;
      w_xsub_next     = '0;
      w_ysub_next     = '0;
    end else begin
      case (r_state)
        LINE_WAIT, LINE_ACTIVE: begin
          if (w_in_win) begin
            w_state_next = LINE_ACTIVE;
            if (32'(w_xsub_cur) == SCALE - 1) begin
              w_xsub_next = '0;
              w_col_next  = w_col_cur + COL_W'(1);
            end else begin
              w_xsub_next = w_xsub_cur + SUB_W'(1);
              w_col_next  = w_col_cur;
            end
          end else if (r_state == LINE_ACTIVE) begin
            w_state_next = LINE_WAIT;
            if (32'(r_ysub) == SCALE - 1) begin
              w_ysub_next     = '0;
              w_row_base_next = r_row_base + ADDR_W'(IMG_WIDTH);
            end else begin
              w_ysub_next = r_ysub + SUB_W'(1);
            end
          end else if (w_last_line_done) begin
            w_state_next = FRAME_WAIT;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (DLY),
    .WIDTH (2)
  ) u_flag_dly (
    .i_clk (clk_25),
    .i_rst (rst),
    .i_d   ({w_pix_en, w_border}),
    .o_q   (w_dly_q)
  );

  assign w_gray = bus.pixel_data[PIX_W-1 -: 8];

  // State, counters, frame latch, address and colour registers.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_state         <= FRAME_WAIT;
      r_row_base      <= '0;
      r_col           <= '0;
      r_xsub          <= '0;
      r_ysub          <= '0;
      r_active_img    <= '0;
      r_frame_start   <= 1'b0;
      r_pixel_address <= '0;
      r_rgb           <= BG_COLOR;
    end else begin
      r_state         <= w_state_next;
      r_row_base      <= w_row_base_next;
      r_col           <= w_col_next;
      r_xsub          <= w_xsub_next;
      r_ysub          <= w_ysub_next;
      r_frame_start   <= w_frame_latch;
      if (w_frame_latch) r_active_img <= w_active_next;
      r_pixel_address <= w_pix_en ? w_addr : '0;
      if (w_dly_q[1])      r_rgb <= {w_gray, w_gray, w_gray};
      else if (w_dly_q[0]) r_rgb <= BORDER_COLOR;
      else                 r_rgb <= BG_COLOR;
    end
  end

  assign bus.pixel_address = r_pixel_address;
  assign bus.r             = r_rgb[23:16];
  assign bus.g             = r_rgb[15:8];
  assign bus.b             = r_rgb[7:0];
  assign bus.frame_start   = r_frame_start;
  assign bus.active_img    = r_active_img;

endmodule

// File: tb/tb_image_window_renderer.sv
// Bench for image_window_renderer: a default 400x400 instance and a small
// 4x2, x2-zoom, latency-3, three-image instance driven by one shared scan.
module tb_image_window_renderer;
  import renderer_pkg::*;

  localparam int A_HS = 120, A_VS = 40, A_W = 400, A_H = 400, A_S = 1, A_L = 1;
  localparam int B_HS = 10,  B_VS = 5,  B_W = 4,   B_H = 2,   B_S = 2, B_L = 3;

`ifdef RENDERER_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic       clk_25 = 1'b0;
  logic       rst    = 1'b1;
  logic [9:0] hs     = '0;
  logic [9:0] vs     = '0;
  logic       sel_a  = 1'b0;
  logic [1:0] sel_b  = 2'd0;

  always #20 clk_25 = ~clk_25;

  image_window_renderer_if #(.ADDR_W(19), .PIX_W(8), .SEL_W(1)) ifa ();
  image_window_renderer_if #(.ADDR_W(19), .PIX_W(8), .SEL_W(2)) ifb ();

  assign ifa.hs = hs;
  assign ifa.vs = vs;
  assign ifa.img_sel = sel_a;
  assign ifb.hs = hs;
  assign ifb.vs = vs;
  assign ifb.img_sel = sel_b;

  image_window_renderer dut_a (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (ifa)
  );

  image_window_renderer #(
    .IMG_WIDTH   (4),
    .IMG_HEIGHT  (2),
    .NUM_IMAGES  (3),
    .H_START     (10),
    .V_START     (5),
    .SCALE       (2),
    .MEM_LATENCY (3)
  ) dut_b (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (ifb)
  );

  function automatic logic [7:0] mem_f(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Image RAM models: latency 1 for A, latency 3 for B.
  logic [18:0] b_pipe0 = '0, b_pipe1 = '0;
  always @(posedge clk_25) begin
    ifa.pixel_data <= mem_f(32'(ifa.pixel_address));
    b_pipe0        <= ifb.pixel_address;
    b_pipe1        <= b_pipe0;
    ifb.pixel_data <= mem_f(32'(b_pipe1));
  end

  typedef struct {
    int          due;
    int          unit;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   val_a  = 1'b0, val_b = 1'b0;
  int   act_a  = 0,    act_b = 0;

  function automatic bit in_win(input int h, v, h0, v0, w, ht, s);
    return (h >= h0) && (h < h0 + w * s) && (v >= v0) && (v < v0 + ht * s);
  endfunction

  function automatic bit on_border(input int h, v, h0, v0, w, ht, s);
    int h1, v1;
    h1 = h0 + w * s;
    v1 = v0 + ht * s;
    return (((h == h0 - 1) || (h == h1)) && (v >= v0 - 1) && (v <= v1)) ||
           (((v == v0 - 1) || (v == v1)) && (h >= h0 - 1) && (h <= h1));
  endfunction

  function automatic logic [31:0] mdl_addr(input int h, v, h0, v0, w, s, base);
    return 32'(base + ((v - v0) / s) * w + (h - h0) / s);
  endfunction

  task automatic compare(input int unit, input logic [31:0] e);
    logic [31:0] obs;
    string       tag;
    case (unit)
      0:       begin obs = 32'(ifa.pixel_address);     tag = "a_addr";  end
      1:       begin obs = 32'({ifa.r, ifa.g, ifa.b}); tag = "a_rgb";   end
      2:       begin obs = 32'(ifb.pixel_address);     tag = "b_addr";  end
      3:       begin obs = 32'({ifb.r, ifb.g, ifb.b}); tag = "b_rgb";   end
      4:       begin obs = 32'(ifa.frame_start);       tag = "a_fs";    end
      5:       begin obs = 32'(ifa.active_img);        tag = "a_act";   end
      6:       begin obs = 32'(ifb.frame_start);       tag = "b_fs";    end
      default: begin obs = 32'(ifb.active_img);        tag = "b_act";   end
    endcase
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, e);
    end
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        compare(sb[i].unit, sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    cyc++;
    #1;
    check_due();
  endtask

  // Present one scan position for one clock and queue what both DUTs owe for it.
  task automatic drive(input int h, input int v);
    logic [31:0] a;
    logic [23:0] rgb;
    bit          p;
    hs = 10'(h);
    vs = 10'(v);
    if (h == 0 && v == 0) begin
      act_a = int'(sel_a);
      if (sel_b < 2'd3) act_b = int'(sel_b);
      val_a = 1'b1;
      val_b = 1'b1;
    end
    p   = val_a && in_win(h, v, A_HS, A_VS, A_W, A_H, A_S);
    a   = p ? mdl_addr(h, v, A_HS, A_VS, A_W, A_S, act_a * A_W * A_H) : 32'd0;
    rgb = p ? {3{mem_f(a)}} :
          (BORDER_ON && on_border(h, v, A_HS, A_VS, A_W, A_H, A_S)) ? BORDER_COLOR : 24'h000000;
    sb.push_back('{cyc + 1, 0, a});
    sb.push_back('{cyc + 2 + A_L, 1, 32'(rgb)});
    sb.push_back('{cyc + 1, 4, 32'(h == 0 && v == 0)});
    sb.push_back('{cyc + 1, 5, 32'(act_a)});
    p   = val_b && in_win(h, v, B_HS, B_VS, B_W, B_H, B_S);
    a   = p ? mdl_addr(h, v, B_HS, B_VS, B_W, B_S, act_b * B_W * B_H) : 32'd0;
    rgb = p ? {3{mem_f(a)}} :
          (BORDER_ON && on_border(h, v, B_HS, B_VS, B_W, B_H, B_S)) ? BORDER_COLOR : 24'h000000;
    sb.push_back('{cyc + 1, 2, a});
    sb.push_back('{cyc + 2 + B_L, 3, 32'(rgb)});
    sb.push_back('{cyc + 1, 6, 32'(h == 0 && v == 0)});
    sb.push_back('{cyc + 1, 7, 32'(act_b)});
    tick();
  endtask

  task automatic scan_b_window();
    for (int v = 4; v <= 9; v++)
      for (int h = 8; h <= 19; h++) drive(h, v);
  endtask

  initial begin
    // Reset held for three clocks while the scan runs inside window A.
    rst = 1'b1;
    hs  = 10'd130;
    vs  = 10'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      hs = hs + 10'd1;
    end
    for (int u = 0; u < 8; u++) compare(u, 32'd0);
    rst = 1'b0;

    // Frame 1: image 0 in both instances.
    sel_a = 1'b0;
    sel_b = 2'd0;
    drive(799, 524);
    drive(0, 0);
    drive(1, 0);
    scan_b_window();
    for (int h = 118; h <= 125; h++) drive(h, 40);
    drive(600, 40);
    for (int h = 119; h <= 122; h++) drive(h, 41);
    drive(600, 41);

    // Mid-frame select change must not affect the current frame.
    sel_a = 1'b1;
    sel_b = 2'd1;
    for (int h = 119; h <= 121; h++) drive(h, 42);
    drive(600, 42);
    drive(119, 100);
    drive(600, 100);

    // Frame 2: image 1 everywhere.
    drive(0, 0);
    drive(1, 0);
    scan_b_window();
    for (int h = 119; h <= 122; h++) drive(h, 40);
    drive(600, 40);

    // Frame 3: out-of-range select on B holds image 1; A returns to image 0.
    sel_a = 1'b0;
    sel_b = 2'd3;
    drive(0, 0);
    drive(1, 0);
    for (int h = 9; h <= 13; h++) drive(h, 5);
    drive(19, 5);
    for (int h = 119; h <= 121; h++) drive(h, 40);

    // Drain outstanding expectations with a bounded number of idle clocks.
    hs = 10'd700;
    vs = 10'd300;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
